// File: rtl/gen_gamma_pkg.sv
// Shared types and constants for the gamma-coding key sequencer.
// The state encoding is private to the sequencer; the stage counts size the front end.
package gen_gamma_pkg;

  typedef enum logic [2:0] {
    PRIME,
    COLLECT,
    CHECK,
    ARMED,
    SEND,
    FAULT
  } state_t;

  localparam int SYNC_STAGES  = 2;
  localparam int PRIME_CYCLES = 2;

endpackage

// File: rtl/gamma_key_sequencer_key_collector.sv
// Entropy front end: synchronises the oscillator bank and shifts RAND_W bits per enabled
// cycle into a SIZE-bit key. key_done marks the shift that completes a key.
module key_collector
  import gen_gamma_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int RAND_W = 4
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic [RAND_W-1:0] rand_bits,
  input  logic              shift_en,
  input  logic              clear,
  output logic [SIZE-1:0]   key,
  output logic              key_done
);

  localparam int N     = SIZE / RAND_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  logic [RAND_W-1:0]      sync_q [SYNC_STAGES];
  logic [RAND_W-1:0]      rand_sync;
  logic [CNT_W-1:0]       cnt;
  logic [SIZE+RAND_W-1:0] shifted;

  // NOTE: the synchroniser is a handful of flops, not a RAM, so every stage gets a reset.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rand_bits;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rand_sync = sync_q[SYNC_STAGES-1];
  assign shifted   = {key, rand_sync};
  assign key_done  = shift_en && (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      key <= '0;
      cnt <= '0;
    end else begin
      if (shift_en) key <= shifted[SIZE-1:0];
      if (clear) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= key_done ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gamma_key_sequencer.sv
// Collects and health-checks one fresh entropy key per plaintext word and emits
// {carry, data + key} under valid/ready handshakes; raises a sticky fault on entropy stalls.
module gamma_key_sequencer
  import gen_gamma_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int RAND_W    = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic [RAND_W-1:0] rand_bits,
  input  logic              in_valid,
  input  logic [SIZE-1:0]   in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [SIZE:0]     out_data,
  input  logic              out_ready,
  output logic              key_fault
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int PRIME_W = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;

  if (SIZE % RAND_W != 0) begin : gen_size_check
    $error("gamma_key_sequencer: SIZE must be a multiple of RAND_W");
  end
  if (MAX_RETRY < 1) begin : gen_retry_check
    $error("gamma_key_sequencer: MAX_RETRY must be at least 1");
  end

  state_t               state;
  logic [PRIME_W-1:0]   prime_cnt;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [SIZE-1:0]      key;
  logic [SIZE-1:0]      last_key;
  logic                 last_key_vld;
  logic                 key_done;
  logic                 key_reject;
  logic                 shift_en;
  logic                 clear;

  assign shift_en = (state == COLLECT);
  assign clear    = (state == SEND) && out_ready;

  key_collector #(
    .SIZE   (SIZE),
    .RAND_W (RAND_W)
  ) u_key_collector (
    .clk       (clk),
    .res_n     (res_n),
    .rand_bits (rand_bits),
    .shift_en  (shift_en),
    .clear     (clear),
    .key       (key),
    .key_done  (key_done)
  );

  // A stuck-at-zero source or a repeated key both count as an unhealthy key.
  assign key_reject = (key == '0) || (last_key_vld && (key == last_key));
  assign in_ready   = (state == ARMED);

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state        <= PRIME;
      prime_cnt    <= '0;
      retry_cnt    <= '0;
      last_key     <= '0;
      last_key_vld <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      key_fault    <= 1'b0;
    end else begin
      case (state)
        PRIME: begin
          if (prime_cnt == PRIME_W'(PRIME_CYCLES - 1)) state <= COLLECT;
          else prime_cnt <= prime_cnt + 1'b1;
        end
        COLLECT: begin
          if (key_done) state <= CHECK;
        end
        CHECK: begin
          if (key_reject) begin
            retry_cnt <= retry_cnt + 1'b1;
            if (retry_cnt == RETRY_W'(MAX_RETRY - 1)) begin
              state     <= FAULT;
              key_fault <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end else begin
            last_key     <= key;
            last_key_vld <= 1'b1;
            retry_cnt    <= '0;
            state        <= ARMED;
          end
        end
        ARMED: begin
          if (in_valid) begin
            out_data  <= {1'b0, in_data} + {1'b0, key};
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // out_data stays frozen until the consumer takes it; the key is then discarded.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        FAULT: begin
          key_fault <= 1'b1;
          out_valid <= 1'b0;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_key_sequencer.sv
// Directed-plus-random bench for gamma_key_sequencer: keys are steered through rand_bits
// and every coded word is compared against plain data + key arithmetic.
module tb_gamma_key_sequencer;

  localparam int SIZE   = 8;
  localparam int RAND_W = 4;
  localparam int N      = SIZE / RAND_W;

  logic             clk = 1'b0;
  logic             res_n;
  logic [RAND_W-1:0] rand_bits;
  logic             in_valid;
  logic [SIZE-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic [SIZE:0]    out_data;
  logic             out_ready;
  logic             key_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gamma_key_sequencer #(
    .SIZE      (SIZE),
    .RAND_W    (RAND_W),
    .MAX_RETRY (3)
  ) dut (
    .clk       (clk),
    .res_n     (res_n),
    .rand_bits (rand_bits),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .key_fault (key_fault)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SIZE:0] coded(input logic [SIZE-1:0] d, input logic [SIZE-1:0] k);
    int sum;
    sum = int'(d) + int'(k);
    return sum[SIZE:0];
  endfunction

  // Expect in_ready low for n-1 cycles and high on the n-th.
  task automatic expect_ready(input string tag, input int n);
    for (int i = 1; i < n; i++) begin
      step();
      check({tag, "_wait_ready"}, in_ready, 1'b0);
      check({tag, "_wait_fault"}, key_fault, 1'b0);
    end
    step();
    check({tag, "_ready"}, in_ready, 1'b1);
  endtask

  // In ARMED: optional idle cycles, then one handshake; leaves the DUT in SEND.
  task automatic send_word(input string tag, input logic [SIZE-1:0] d,
                           input logic [SIZE-1:0] k, input int idle);
    for (int i = 0; i < idle; i++) begin
      step();
      check({tag, "_idle_ready"}, in_ready, 1'b1);
      check({tag, "_idle_valid"}, out_valid, 1'b0);
    end
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = SIZE'($urandom);
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_out_data"}, out_data, coded(d, k));
    check({tag, "_busy"}, in_ready, 1'b0);
  endtask

  // In SEND: stall, then release the word while presenting the nibbles of the next key.
  // The collector's first shift uses rand_bits from two edges before it (synchroniser depth).
  task automatic release_with_key(input string tag, input logic [RAND_W-1:0] hi,
                                  input logic [RAND_W-1:0] lo, input int stall,
                                  input logic [SIZE:0] held);
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_data"}, out_data, held);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
    end
    rand_bits = hi;
    step();
    check({tag, "_hold_valid"}, out_valid, 1'b1);
    check({tag, "_hold_data"}, out_data, held);
    rand_bits = lo;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_released"}, out_valid, 1'b0);
  endtask

  task automatic restart(input string tag, input bit immediate);
    rand_bits = 4'hA;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    res_n     = 1'b0;
    #1;
    if (immediate) begin
      check({tag, "_async_valid"}, out_valid, 1'b0);
      check({tag, "_async_fault"}, key_fault, 1'b0);
      check({tag, "_async_data"}, out_data, 9'h000);
    end
    step();
    check({tag, "_rst_valid"}, out_valid, 1'b0);
    check({tag, "_rst_data"}, out_data, 9'h000);
    check({tag, "_rst_ready"}, in_ready, 1'b0);
    check({tag, "_rst_fault"}, key_fault, 1'b0);
    res_n = 1'b1;
    expect_ready({tag, "_startup"}, 5);
  endtask

  initial begin
    logic [RAND_W-1:0] hi;
    logic [RAND_W-1:0] lo;
    logic [SIZE-1:0]   cur_key;
    logic [SIZE-1:0]   nxt_key;
    logic [SIZE-1:0]   d;
    logic [SIZE:0]     cur_out;

    in_data = '0;

    // Reset and first key AA, then 0x60 + 0xAA.
    restart("s1", 1'b0);
    send_word("s2a", 8'h60, 8'hAA, 0);
    check("s2a_const", out_data, 9'h10A);

    // Long stall in SEND while the next key C3 is set up.
    release_with_key("s5", 4'hC, 4'h3, 9, 9'h10A);
    expect_ready("s2b", N + 1);
    send_word("s2b", 8'h55, 8'hC3, 2);
    check("s2b_const", out_data, 9'h118);
    cur_key = 8'hC3;
    cur_out = 9'h118;

    // Random keys, data, stalls and idle gaps, no rejects.
    for (int w = 0; w < 16; w++) begin
      do begin
        hi      = RAND_W'($urandom_range(0, 15));
        lo      = RAND_W'($urandom_range(0, 15));
        nxt_key = {hi, lo};
      end while (nxt_key == 8'h00 || nxt_key == cur_key || nxt_key == 8'h33 ||
                 nxt_key == 8'h55 || nxt_key == 8'hAA);
      release_with_key("rnd", hi, lo, int'($urandom_range(0, 3)), cur_out);
      expect_ready("rnd", N + 1);
      d = SIZE'($urandom);
      send_word("rnd", d, nxt_key, int'($urandom_range(0, 2)));
      cur_key = nxt_key;
      cur_out = coded(d, nxt_key);
    end

    // Two zero keys then a good one, twice: retries must clear on each accept.
    for (int r = 0; r < 2; r++) begin
      release_with_key("s4", 4'h0, 4'h0, 0, cur_out);
      for (int i = 0; i < 4; i++) begin
        step();
        check("s4_retry_ready", in_ready, 1'b0);
        check("s4_retry_fault", key_fault, 1'b0);
      end
      rand_bits = (r == 0) ? 4'h3 : 4'h5;
      expect_ready("s4", 5);
      cur_key = (r == 0) ? 8'h33 : 8'h55;
      d       = SIZE'($urandom);
      send_word("s4", d, cur_key, 0);
      cur_out = coded(d, cur_key);
      check("s4_fault_clear", key_fault, 1'b0);
    end

    // Key AA once more, then the same key repeats until the fault latches.
    release_with_key("s3a", 4'hA, 4'hA, 0, cur_out);
    expect_ready("s3a", N + 1);
    d = SIZE'($urandom);
    send_word("s3a", d, 8'hAA, 0);
    cur_out = coded(d, 8'hAA);
    release_with_key("s3", 4'hA, 4'hA, 0, cur_out);
    for (int i = 0; i < 8; i++) begin
      step();
      check("s3_pre_fault", key_fault, 1'b0);
      check("s3_pre_ready", in_ready, 1'b0);
    end
    step();
    check("s3_fault_set", key_fault, 1'b1);
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      step();
      check("s3_fault_ready", in_ready, 1'b0);
      check("s3_fault_valid", out_valid, 1'b0);
      check("s3_fault_sticky", key_fault, 1'b1);
    end
    in_valid = 1'b0;

    // Reset during FAULT, then during SEND.
    restart("s6a", 1'b1);
    send_word("s6a", 8'h60, 8'hAA, 0);
    restart("s6b", 1'b1);
    send_word("s6b", 8'hFF, 8'hAA, 1);
    check("s6b_carry", out_data, 9'h1A9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
